// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// State encoding, byte lanes, address helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CHK,
    S_DONE
  } state_t;

  localparam int BYTE_W = 8;
  localparam int LANES = 4;
  localparam int LANE_W = 2;
  localparam logic [LANE_W-1:0] LAST_LANE = 2'd3;

  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [31:0] idx
  );
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream valid/ready bundle.
// Master drives bytes, slave returns ready.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              s_valid;
  logic [BYTE_W-1:0] s_data;
  logic              s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler.
// Pulses word_valid with the 4th byte of each word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_word_valid,
  output logic [31:0]       o_word
);

  logic [LANE_W-1:0] r_lane;
  logic [23:0]       r_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_sh   <= '0;
    end else if (i_clr) begin
      r_lane <= '0;
      r_sh   <= '0;
    end else if (i_en) begin
      r_lane <= r_lane + 1'b1;
      r_sh   <= {i_byte, r_sh[23:8]};
    end
  end

  // Bytes arrive low lane first, so the newest byte is the top lane.
  assign o_word_valid = i_en && (r_lane == LAST_LANE);
  assign o_word       = {i_byte, r_sh};

endmodule

// File: rtl/imem_loader.sv
// IMEM writer: header, packed words, XOR checksum.
// Holds the core in reset until a good load lands.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  imem_loader_if.slave     s,
  output logic             o_we,
  output logic [31:0]      o_wa,
  output logic [31:0]      o_wd,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic             o_cpu_rst_n
);

  state_t r_state;
  state_t w_next;

  logic [BYTE_W-1:0] r_lo;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_cnt;
  logic [BYTE_W-1:0] r_csum;
  logic              r_we;
  logic [31:0]       r_wa;
  logic [31:0]       r_wd;
  logic              r_done;
  logic              r_err;
  logic              r_cpu_rst_n;

  logic              w_busy;
  logic              w_acc;
  logic              w_start_ok;
  logic [CNT_W-1:0]  w_n;
  logic              w_over;
  logic              w_wv;
  logic [31:0]       w_word;
  logic              w_last;
  logic              w_csum_ok;
  logic              w_pk_en;

  assign w_busy = (r_state == S_HDR0) ||
                  (r_state == S_HDR1) ||
                  (r_state == S_DATA) ||
                  (r_state == S_CHK);
  assign w_acc = s.s_valid && w_busy;
  assign w_start_ok = i_start &&
    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_n = CNT_W'({s.s_data, r_lo});
  assign w_over = w_n > CNT_W'(DEPTH);
  assign w_pk_en = w_acc && (r_state == S_DATA);
  assign w_last = w_wv &&
    ((r_cnt + CNT_W'(1)) == r_n);
  assign w_csum_ok = (s.s_data == r_csum);

  imem_loader_byte_packer u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_start_ok),
    .i_en         (w_pk_en),
    .i_byte       (s.s_data),
    .o_word_valid (w_wv),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) w_next = S_HDR0;
      end
      S_HDR0: begin
        if (w_acc) w_next = S_HDR1;
      end
      S_HDR1: begin
        if (w_acc) begin
          if (w_over)          w_next = S_IDLE;
          else if (w_n == '0)  w_next = S_CHK;
          else                 w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) w_next = S_CHK;
      end
      S_CHK: begin
        if (w_acc) begin
          w_next = w_csum_ok ? S_DONE : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lo        <= '0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_cnt       <= '0;
        r_csum      <= '0;
        r_cpu_rst_n <= 1'b0;
      end
      if (w_acc && r_state == S_HDR0) begin
        r_lo <= s.s_data;
      end
      if (w_acc && r_state == S_HDR1) begin
        r_n <= w_n;
        if (w_over) r_err <= 1'b1;
      end
      if (w_pk_en) begin
        r_csum <= r_csum ^ s.s_data;
        if (w_wv) begin
          r_we  <= 1'b1;
          r_wa  <= word_addr(BASE_ADDR, 32'(r_cnt));
          r_wd  <= w_word;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_acc && r_state == S_CHK) begin
        if (w_csum_ok) begin
          r_done      <= 1'b1;
          r_cpu_rst_n <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign s.s_ready   = w_busy;
  assign o_busy      = w_busy;
  assign o_we        = r_we;
  assign o_wa        = r_wa;
  assign o_wd        = r_wd;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_word_cnt  = r_cnt;
  assign o_cpu_rst_n = r_cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Hand-computed words, addresses and checksums.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_cnt;
  logic        cpu_rst_n;

  imem_loader_if sif ();

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .s           (sif.slave),
    .o_we        (we),
    .o_wa        (wa),
    .o_wd        (wd),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_word_cnt  (word_cnt),
    .o_cpu_rst_n (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (we === 1'b1) we_cnt++;
  end

  logic [7:0]  good [12] = '{8'h02, 8'h00,
    8'h03, 8'hA3, 8'hC4, 8'hFF,
    8'h83, 8'h23, 8'h83, 8'h00, 8'hB8, 8'h00};
  logic [7:0]  bad  [12] = '{8'h02, 8'h00,
    8'h03, 8'hA3, 8'hC4, 8'hFF,
    8'h83, 8'h23, 8'h83, 8'h00, 8'h00, 8'h00};
  logic [7:0]  over [12] = '{8'h41, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0]  empt [12] = '{8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00};
  logic [31:0] exp_wd [2] = '{32'hFFC4A303,
    32'h00832383};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    sif.s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    sif.s_valid = 1'b1;
    sif.s_data  = b;
    @(negedge clk);
    sif.s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input logic [7:0] st [12],
                      input int nb,
                      input int nw,
                      input bit gaps,
                      input int mid_at);
    bit last;
    int k;
    for (int i = 0; i < nb; i++) begin
      if (gaps) idle($urandom_range(1, 3));
      if (i == mid_at) pulse_start();
      send(st[i]);
      k = i - 2;
      last = (i >= 2) && (k < 4 * nw) &&
             (k % 4 == 3);
      chk("we", 32'(we), 32'(last));
      if (last) begin
        chk("wa", wa, 32'(4 * (k / 4)));
        chk("wd", wd, exp_wd[k / 4]);
      end
    end
  endtask

  int w0;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(sif.s_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(word_cnt), 0);
    chk("rst_cpu", 32'(cpu_rst_n), 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    rst_n = 1'b1;
    idle(2);

    w0 = we_cnt;
    pulse_start();
    chk("g_busy0", 32'(busy), 1);
    chk("g_rdy0", 32'(sif.s_ready), 1);
    load(good, 11, 2, 0, -1);
    idle(1);
    chk("g_done", 32'(done), 1);
    chk("g_err", 32'(err), 0);
    chk("g_cpu", 32'(cpu_rst_n), 1);
    chk("g_cnt", 32'(word_cnt), 2);
    chk("g_busy", 32'(busy), 0);
    chk("g_rdy", 32'(sif.s_ready), 0);
    chk("g_nwe", 32'(we_cnt - w0), 2);
    idle(3);
    chk("g_hold", 32'(done), 1);

    w0 = we_cnt;
    pulse_start();
    chk("b_clr", 32'(done), 0);
    load(bad, 11, 2, 0, -1);
    idle(1);
    chk("b_err", 32'(err), 1);
    chk("b_done", 32'(done), 0);
    chk("b_cpu", 32'(cpu_rst_n), 0);
    chk("b_busy", 32'(busy), 0);
    chk("b_rdy", 32'(sif.s_ready), 0);
    chk("b_cnt", 32'(word_cnt), 2);
    chk("b_nwe", 32'(we_cnt - w0), 2);

    w0 = we_cnt;
    pulse_start();
    chk("o_clr", 32'(err), 0);
    load(over, 2, 0, 0, -1);
    chk("o_err", 32'(err), 1);
    chk("o_rdy", 32'(sif.s_ready), 0);
    chk("o_busy", 32'(busy), 0);
    idle(2);
    chk("o_nwe", 32'(we_cnt - w0), 0);

    w0 = we_cnt;
    pulse_start();
    load(empt, 3, 0, 0, -1);
    idle(1);
    chk("e_done", 32'(done), 1);
    chk("e_err", 32'(err), 0);
    chk("e_cpu", 32'(cpu_rst_n), 1);
    chk("e_cnt", 32'(word_cnt), 0);
    chk("e_nwe", 32'(we_cnt - w0), 0);

    w0 = we_cnt;
    pulse_start();
    load(good, 11, 2, 1, 6);
    idle(1);
    chk("gp_done", 32'(done), 1);
    chk("gp_err", 32'(err), 0);
    chk("gp_cpu", 32'(cpu_rst_n), 1);
    chk("gp_cnt", 32'(word_cnt), 2);
    chk("gp_nwe", 32'(we_cnt - w0), 2);

    w0 = we_cnt;
    pulse_start();
    load(good, 5, 2, 0, -1);
    rst_n = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hFF;
    repeat (2) @(negedge clk);
    sif.s_valid = 1'b0;
    chk("r_we", 32'(we), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_done", 32'(done), 0);
    chk("r_cnt", 32'(word_cnt), 0);
    chk("r_cpu", 32'(cpu_rst_n), 0);
    chk("r_wd", wd, 0);
    rst_n = 1'b1;
    idle(2);
    chk("r_nwe", 32'(we_cnt - w0), 0);
    chk("r_rdy", 32'(sif.s_ready), 0);

    w0 = we_cnt;
    pulse_start();
    load(good, 11, 2, 0, -1);
    idle(1);
    chk("r2_done", 32'(done), 1);
    chk("r2_cpu", 32'(cpu_rst_n), 1);
    chk("r2_cnt", 32'(word_cnt), 2);
    chk("r2_nwe", 32'(we_cnt - w0), 2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
